viterbi_ctrl: RTL and testbench

Parametrised control FSM for the Viterbi decoder datapath. It accepts a frame of symbols through a valid/ready handshake and sequences the branch-metric, path-metric and survivor-memory-write phases for each symbol. It then runs a traceback pass of alternating memory reads and trace steps, reading addresses from the last symbol down to the first. Frame length is set per frame at run time, up to MAX_SEQ. The block drives the enables and the survivor-memory address for the datapath, and reports busy and frame completion to the upper layer.

---
 rtl/viterbi_pkg.sv | 18 +
 rtl/viterbi_addr_cnt.sv | 55 +++++
 rtl/viterbi_ctrl.sv | 137 +++++++++++++
 tb/tb_viterbi_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants for the Viterbi decoder control slice.
//   - Controller state encoding (3 bits, legacy-compatible values)
//   - Default maximum frame length
// Optional feature macro used by the slice: VITERBI_ABORT_EN
package viterbi_pkg;

    localparam int MAX_SEQ_DEF = 64;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_BRANCH    = 3'd1;
    localparam logic [2:0] ST_PATH      = 3'd2;
    localparam logic [2:0] ST_MEM_WRITE = 3'd3;
    localparam logic [2:0] ST_MEM_READ  = 3'd4;
    localparam logic [2:0] ST_TRACE     = 3'd5;
    localparam logic [2:0] ST_WAIT_SYM  = 3'd6;
    localparam logic [2:0] ST_DONE      = 3'd7;

endpackage

// File: rtl/viterbi_addr_cnt.sv
// Survivor-memory address counters for the Viterbi controller.
//   sym_cnt : up-counter for symbol writes, saturates at len_q
//   rd_cnt  : down-counter for traceback reads, saturates at 0
// Ports:
//   CLK, RST              clock, asynchronous active-low reset
//   clr                   clear both counters
//   sym_inc               advance sym_cnt (ignored at terminal count)
//   rd_load / rd_dec      load rd_cnt from len_q / step it down
//   len_q                 latched frame length minus one
//   sym_cnt, rd_cnt       counter values
//   sym_last, rd_zero     terminal-count flags
module viterbi_addr_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             sym_inc,
    input  logic             rd_load,
    input  logic             rd_dec,
    input  logic [CNT_W-1:0] len_q,
    output logic [CNT_W-1:0] sym_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             sym_last,
    output logic             rd_zero
);

    assign sym_last = (sym_cnt == len_q);
    assign rd_zero  = (rd_cnt == '0);

    // Increment is gated by the terminal flag so the counter can never wrap,
    // even when len_q is the all-ones maximum.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sym_cnt <= '0;
        end else if (clr) begin
            sym_cnt <= '0;
        end else if (sym_inc && !sym_last) begin
            sym_cnt <= sym_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_cnt <= '0;
        end else if (clr) begin
            rd_cnt <= '0;
        end else if (rd_load) begin
            rd_cnt <= len_q;
        end else if (rd_dec && !rd_zero) begin
            rd_cnt <= rd_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/viterbi_ctrl.sv
// Control FSM for the Viterbi decoder datapath.
// Accepts a frame of symbols, sequences branch / path / survivor-write per
// symbol, then runs traceback (read, trace, read, ... , read) from the last
// address down to 0 and pulses frame_done.
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   Data_Valid          symbol offered by the upper layer
//   frame_len_m1        frame length minus one, sampled on the first symbol
//   abort               (VITERBI_ABORT_EN only) return to IDLE from any state
//   Data_Ready          controller can take a symbol
//   branch_enable, path_enable, memory_enable, memory_read_enable,
//   trace_enable        datapath phase strobes (at most one high)
//   mem_addr            survivor-memory write/read address, 0 otherwise
//   busy                controller is not idle
//   frame_done          one-cycle pulse at end of traceback
// Optional feature macro: VITERBI_ABORT_EN
//
// Handshake: a symbol transfers on a rising edge where Data_Valid and
// Data_Ready are both high; Data_Ready does not depend on Data_Valid, and
// Data_Valid is ignored whenever Data_Ready is low.
module viterbi_ctrl
    import viterbi_pkg::*;
#(
    parameter int MAX_SEQ = MAX_SEQ_DEF,
    parameter int CNT_W   = $clog2(MAX_SEQ)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Data_Valid,
    input  logic [CNT_W-1:0] frame_len_m1,
`ifdef VITERBI_ABORT_EN
    input  logic             abort,
`endif
    output logic             Data_Ready,
    output logic             branch_enable,
    output logic             path_enable,
    output logic             memory_enable,
    output logic             memory_read_enable,
    output logic             trace_enable,
    output logic [CNT_W-1:0] mem_addr,
    output logic             busy,
    output logic             frame_done
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] sym_cnt, rd_cnt;
    logic             sym_last, rd_zero;
    logic             abort_req;
    logic             frame_start;
    logic             cnt_clr, sym_inc, rd_load, rd_dec;

`ifdef VITERBI_ABORT_EN
    assign abort_req = abort && (state_q != ST_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign frame_start = (state_q == ST_IDLE) && Data_Valid;

    // An abort suppresses every counter update except the clear.
    assign cnt_clr = frame_start || abort_req;
    assign sym_inc = (state_q == ST_MEM_WRITE) && !sym_last && !abort_req;
    assign rd_load = (state_q == ST_MEM_WRITE) && sym_last && !abort_req;
    assign rd_dec  = (state_q == ST_TRACE) && !abort_req;

    viterbi_addr_cnt #(
        .CNT_W (CNT_W)
    ) u_addr_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (cnt_clr),
        .sym_inc  (sym_inc),
        .rd_load  (rd_load),
        .rd_dec   (rd_dec),
        .len_q    (len_q),
        .sym_cnt  (sym_cnt),
        .rd_cnt   (rd_cnt),
        .sym_last (sym_last),
        .rd_zero  (rd_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (Data_Valid) state_d = ST_BRANCH;
            ST_BRANCH:    state_d = ST_PATH;
            ST_PATH:      state_d = ST_MEM_WRITE;
            ST_MEM_WRITE: state_d = sym_last ? ST_MEM_READ : ST_WAIT_SYM;
            ST_WAIT_SYM:  if (Data_Valid) state_d = ST_BRANCH;
            ST_MEM_READ:  state_d = rd_zero ? ST_DONE : ST_TRACE;
            ST_TRACE:     state_d = ST_MEM_READ;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        if (abort_req) state_d = ST_IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame length is only captured on the first symbol; later symbols of
    // the same frame cannot change it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            len_q <= '0;
        end else if (abort_req) begin
            len_q <= '0;
        end else if (frame_start) begin
            len_q <= frame_len_m1;
        end
    end

    assign Data_Ready         = (state_q == ST_IDLE) || (state_q == ST_WAIT_SYM);
    assign branch_enable      = (state_q == ST_BRANCH);
    assign path_enable        = (state_q == ST_PATH);
    assign memory_enable      = (state_q == ST_MEM_WRITE);
    assign memory_read_enable = (state_q == ST_MEM_READ);
    assign trace_enable       = (state_q == ST_TRACE);
    assign frame_done         = (state_q == ST_DONE);
    assign busy               = (state_q != ST_IDLE);

    always_comb begin
        mem_addr = '0;
        case (state_q)
            ST_MEM_WRITE: mem_addr = sym_cnt;
            ST_MEM_READ:  mem_addr = rd_cnt;
            default:      mem_addr = '0;
        endcase
    end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Bench for viterbi_ctrl. Every datapath strobe and frame_done is an event
// {type, mem_addr, cycle}; events are predicted when a symbol is accepted and
// matched against the DUT in a negedge monitor.
// Optional feature macro: VITERBI_ABORT_EN
module tb_viterbi_ctrl;

    localparam int MAX_SEQ = 64;
    localparam int CNT_W   = 6;
    localparam int CYC_W   = 16;
    localparam int W       = 3 + CNT_W + CYC_W;

    localparam logic [2:0] EV_BR = 3'd0;
    localparam logic [2:0] EV_PA = 3'd1;
    localparam logic [2:0] EV_WR = 3'd2;
    localparam logic [2:0] EV_RD = 3'd3;
    localparam logic [2:0] EV_TR = 3'd4;
    localparam logic [2:0] EV_DN = 3'd5;

    // ---------------- clock / reset ----------------
    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             Data_Valid = 1'b0;
    logic [CNT_W-1:0] frame_len_m1 = '0;
`ifdef VITERBI_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic             Data_Ready;
    logic             branch_enable, path_enable, memory_enable;
    logic             memory_read_enable, trace_enable;
    logic [CNT_W-1:0] mem_addr;
    logic             busy, frame_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;

    logic [W-1:0] exp_q[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    viterbi_ctrl #(
        .MAX_SEQ (MAX_SEQ),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .Data_Valid         (Data_Valid),
        .frame_len_m1       (frame_len_m1),
`ifdef VITERBI_ABORT_EN
        .abort              (abort),
`endif
        .Data_Ready         (Data_Ready),
        .branch_enable      (branch_enable),
        .path_enable        (path_enable),
        .memory_enable      (memory_enable),
        .memory_read_enable (memory_read_enable),
        .trace_enable       (trace_enable),
        .mem_addr           (mem_addr),
        .busy               (busy),
        .frame_done         (frame_done)
    );

    // ---------------- scoreboard ----------------
    function automatic void push_ev(input logic [2:0] t, input int a, input int c);
        logic [CNT_W-1:0] av;
        logic [CYC_W-1:0] cv;
        av = CNT_W'(a);
        cv = CYC_W'(c);
        exp_q.push_back({t, av, cv});
    endfunction

    logic [2:0]   m_t;
    logic         m_hit;
    int           m_n;
    logic [W-1:0] m_e;
    logic [W-1:0] m_got;

    always @(negedge CLK) begin
        m_n = int'(branch_enable) + int'(path_enable) + int'(memory_enable)
            + int'(memory_read_enable) + int'(trace_enable) + int'(frame_done);
        checks++;
        if (m_n > 1) begin
            failures++;
            $display("FAIL onehot cycle=%0d active=%0d required<=1", cyc, m_n);
        end
        m_hit = 1'b1;
        m_t   = EV_BR;
        if (branch_enable)           m_t = EV_BR;
        else if (path_enable)        m_t = EV_PA;
        else if (memory_enable)      m_t = EV_WR;
        else if (memory_read_enable) m_t = EV_RD;
        else if (trace_enable)       m_t = EV_TR;
        else if (frame_done)         m_t = EV_DN;
        else                         m_hit = 1'b0;
        checks++;
        if (m_hit) begin
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cycle=%0d got type=%0d addr=%0d required=none",
                         cyc, m_t, mem_addr);
            end else begin
                m_e   = exp_q.pop_front();
                m_got = {m_t, mem_addr, cyc[CYC_W-1:0]};
                if (m_got !== m_e) begin
                    failures++;
                    $display("FAIL event cycle=%0d got type=%0d addr=%0d required type=%0d addr=%0d cycle=%0d",
                             cyc, m_t, mem_addr, m_e[W-1 -: 3], m_e[CYC_W +: CNT_W],
                             m_e[CYC_W-1:0]);
                end
            end
        end else if (mem_addr !== '0) begin
            failures++;
            $display("FAIL idle_addr cycle=%0d got=%0d required=0", cyc, mem_addr);
        end
        if (exp_q.size() != 0) begin
            checks++;
            if (int'(exp_q[0][CYC_W-1:0]) <= cyc) begin
                failures++;
                $display("FAIL missed_event cycle=%0d required type=%0d addr=%0d at cycle=%0d",
                         cyc, exp_q[0][W-1 -: 3], exp_q[0][CYC_W +: CNT_W], exp_q[0][CYC_W-1:0]);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            checks++;
            if (Data_Ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_in_frame cycle=%0d got=%0b required=0", cyc, Data_Ready);
            end
            @(negedge CLK);
            #1;
            n++;
        end
        Data_Valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout cycle=%0d pending=%0d required=0", cyc, exp_q.size());
            exp_q.delete();
        end
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || Data_Ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_done busy=%0b ready=%0b required busy=0 ready=1",
                     busy, Data_Ready);
        end
    endtask

    // Drives one frame of len+1 symbols. Caller must be at a falling edge.
    task automatic run_frame(input int len, input int alt_len, input int stall_sym,
                             input int stall_cyc, input bit hold_valid, input bit drain);
        int n;
        int c;
        for (int s = 0; s <= len; s++) begin
            frame_len_m1 = CNT_W'((s == 0) ? len : alt_len);
            if (s == stall_sym) begin
                Data_Valid = 1'b0;
                n = 0;
                while (!Data_Ready && n < 20) begin @(negedge CLK); n++; end
                for (int k = 0; k < stall_cyc; k++) begin
                    checks++;
                    if (Data_Ready !== 1'b1 || busy !== 1'b1 || branch_enable || path_enable ||
                        memory_enable || memory_read_enable || trace_enable || frame_done) begin
                        failures++;
                        $display("FAIL stall cycle=%0d ready=%0b busy=%0b required ready=1 busy=1 no strobes",
                                 cyc, Data_Ready, busy);
                    end
                    @(negedge CLK);
                end
            end
            Data_Valid = 1'b1;
            n = 0;
            while (!Data_Ready && n < 20) begin @(negedge CLK); n++; end
            checks++;
            if (!Data_Ready) begin
                failures++;
                $display("FAIL accept_timeout symbol=%0d got ready=0 required=1", s);
                Data_Valid = 1'b0;
                exp_q.delete();
                return;
            end
            c = cyc;
            last_acc = c;
            push_ev(EV_BR, 0, c + 1);
            push_ev(EV_PA, 0, c + 2);
            push_ev(EV_WR, s, c + 3);
            if (s == len) begin
                for (int j = 0; j <= len; j++) begin
                    push_ev(EV_RD, len - j, c + 4 + 2 * j);
                    if (j < len) push_ev(EV_TR, 0, c + 5 + 2 * j);
                end
                push_ev(EV_DN, 0, c + 5 + 2 * len);
            end
            @(negedge CLK);
        end
        if (!hold_valid) Data_Valid = 1'b0;
        if (drain) wait_drain();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b0;
        Data_Valid = 1'b1;
        frame_len_m1 = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if (Data_Ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%0b required=1", Data_Ready);
        end
        checks++;
        if ({branch_enable, path_enable, memory_enable, memory_read_enable, trace_enable, frame_done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b required=000000",
                     {branch_enable, path_enable, memory_enable, memory_read_enable, trace_enable, frame_done});
        end
        checks++;
        if (mem_addr !== '0) begin
            failures++; $display("FAIL reset_addr got=%0d required=0", mem_addr);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%0b required=0", busy);
        end
        // Released at a falling edge with Data_Valid high: the very next
        // rising edge must accept, which the BRANCH event timing enforces.
        RST = 1'b1;
        run_frame(0, 0, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_full_frame();
        run_frame(3, 3, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        run_frame(3, 3, 2, 5, 1'b0, 1'b1);
    endtask

    task automatic test_single_symbol();
        run_frame(0, 0, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_max_len();
        run_frame(MAX_SEQ - 1, MAX_SEQ - 1, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_len_change();
        run_frame(3, 7, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_valid_in_traceback();
        run_frame(3, 3, -1, 0, 1'b1, 1'b1);
    endtask

    task automatic test_random_frames();
        int l;
        for (int i = 0; i < 3; i++) begin
            l = int'($urandom_range(1, 9));
            run_frame(l, int'($urandom_range(0, 15)), int'($urandom_range(1, l)),
                      int'($urandom_range(1, 4)), 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset_midframe();
        int c;
        int n;
        run_frame(3, 3, -1, 0, 1'b0, 1'b0);
        c = last_acc;
        n = 0;
        // Second trace step of a 4-symbol frame runs with rd_cnt=2.
        while (cyc != c + 7 && n < 50) begin @(negedge CLK); n++; end
        #1;
        RST = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (busy !== 1'b0 || Data_Ready !== 1'b1 || trace_enable !== 1'b0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL reset_abort busy=%0b ready=%0b trace=%0b addr=%0d required 0/1/0/0",
                     busy, Data_Ready, trace_enable, mem_addr);
        end
        repeat (4) begin
            @(negedge CLK);
            checks++;
            if (frame_done !== 1'b0) begin
                failures++; $display("FAIL reset_no_done got=%0b required=0", frame_done);
            end
        end
        RST = 1'b1;
        @(negedge CLK);
    endtask

`ifdef VITERBI_ABORT_EN
    task automatic test_abort();
        int c;
        int n;
        frame_len_m1 = CNT_W'(3);
        Data_Valid = 1'b1;
        n = 0;
        while (!Data_Ready && n < 20) begin @(negedge CLK); n++; end
        c = cyc;
        push_ev(EV_BR, 0, c + 1);
        push_ev(EV_PA, 0, c + 2);
        @(negedge CLK);
        Data_Valid = 1'b0;
        @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || Data_Ready !== 1'b1 || memory_enable !== 1'b0) begin
            failures++;
            $display("FAIL abort_path busy=%0b ready=%0b mem_en=%0b required 0/1/0",
                     busy, Data_Ready, memory_enable);
        end
        abort = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_pending got=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_single_symbol();
        test_max_len();
        test_len_change();
        test_valid_in_traceback();
        test_reset_midframe();
`ifdef VITERBI_ABORT_EN
        test_abort();
`endif
        test_random_frames();
        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
